// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI peripheral endpoint, all CPOL/CPHA modes, MSB first, oversampled into clk.
// Macro SPI_SLAVE_LOOPBACK_EN: when defined the default tx word echoes rx_data, otherwise all ones.
module spi_slave_core #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              polarity,
   input  logic              phase,
   input  logic              spi_clk,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              rx_overrun,
   output logic              frame_err
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;
   state_t r_state, w_next;

   logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_clk_d;
   logic                   w_s_clk, w_s_cs, w_s_mosi;
   logic                   w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;

   logic                   r_cpol, r_cpha;
   logic [CNT_W-1:0]       r_cnt;
   logic [DATA_W-1:0]      r_rx_shift, r_tx_shift, r_tx_pend, r_rx_data;
   logic                   r_tx_valid, r_rx_valid, r_overrun, r_frame_err, r_miso;
   logic [DATA_W-1:0]      w_tx_default, w_tx_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_sync  <= {SYNC_STAGES{polarity}};
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_clk_d     <= polarity;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_clk_d     <= w_s_clk;
      end
   end

   assign w_s_clk  = r_clk_sync[SYNC_STAGES-1];
   assign w_s_cs   = r_cs_sync[SYNC_STAGES-1];
   assign w_s_mosi = r_mosi_sync[SYNC_STAGES-1];

   // Leading/trailing depend on idle level; sample/shift then pick per CPHA.
   assign w_rise   = w_s_clk & ~r_clk_d;
   assign w_fall   = ~w_s_clk & r_clk_d;
   assign w_lead   = r_cpol ? w_fall : w_rise;
   assign w_trail  = r_cpol ? w_rise : w_fall;
   assign w_sample = r_cpha ? w_trail : w_lead;
   assign w_shift  = r_cpha ? w_lead : w_trail;

`ifdef SPI_SLAVE_LOOPBACK_EN
   assign w_tx_default = r_rx_data;
`else
   assign w_tx_default = '1;
`endif
   assign w_tx_word = r_tx_valid ? r_tx_pend : w_tx_default;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (!w_s_cs) w_next = SHIFT;
         SHIFT: begin
            if (w_s_cs) begin
               w_next = IDLE;
            end else if (w_sample && (r_cnt == LAST_BIT)) begin
               w_next = DONE;
            end
         end
         DONE:    w_next = w_s_cs ? IDLE : WAIT_CS;
         WAIT_CS: if (w_s_cs) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpol      <= polarity;
         r_cpha      <= phase;
         r_cnt       <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_tx_pend   <= '0;
         r_tx_valid  <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         r_miso      <= 1'b1;
      end else begin
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         if (rx_ack) r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cpol <= polarity;
               r_cpha <= phase;
               r_miso <= 1'b1;
               if (!w_s_cs) begin
                  // A tx_load coinciding with the frame start loses to the default word.
                  r_cnt      <= '0;
                  r_rx_shift <= '0;
                  r_tx_valid <= 1'b0;
                  if (!phase) begin
                     r_miso     <= w_tx_word[DATA_W-1];
                     r_tx_shift <= {w_tx_word[DATA_W-2:0], 1'b1};
                  end else begin
                     r_tx_shift <= w_tx_word;
                  end
               end else if (tx_load && !r_tx_valid) begin
                  r_tx_pend  <= tx_data;
                  r_tx_valid <= 1'b1;
               end
            end
            SHIFT: begin
               if (w_s_cs) begin
                  r_frame_err <= (r_cnt != '0);
                  r_miso      <= 1'b1;
               end else begin
                  if (w_sample) begin
                     r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_s_mosi};
                     r_cnt      <= r_cnt + 1'b1;
                  end
                  if (w_shift) begin
                     r_miso     <= r_tx_shift[DATA_W-1];
                     r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b1};
                  end
               end
            end
            DONE: begin
               r_rx_data  <= r_rx_shift;
               r_rx_valid <= 1'b1;
               r_overrun  <= r_rx_valid & ~rx_ack;
               r_miso     <= 1'b1;
            end
            default: r_miso <= 1'b1;
         endcase
      end
   end

   assign miso       = r_miso | w_s_cs;
   assign tx_ready   = (r_state == IDLE) && !r_tx_valid;
   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign rx_overrun = r_overrun;
   assign frame_err  = r_frame_err;

endmodule
